// File: rtl/mem_arbiter.sv
// Two-master arbiter for a single-port RAM with lockable bursts and a starvation hold cap.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; fixed m0 priority otherwise.
module mem_arbiter #(
  parameter int unsigned AW       = 13,
  parameter int unsigned DW       = 8,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_m0_req,
  input  logic          i_m1_req,
  input  logic          i_m0_lock,
  input  logic          i_m1_lock,
  input  logic [AW-1:0] i_m0_addr,
  input  logic [AW-1:0] i_m1_addr,
  input  logic          i_m0_we,
  input  logic          i_m1_we,
  input  logic [DW-1:0] i_m0_wdata,
  input  logic [DW-1:0] i_m1_wdata,
  output logic          o_m0_gnt,
  output logic          o_m1_gnt,
  output logic [DW-1:0] o_m0_rdata,
  output logic [DW-1:0] o_m1_rdata,
  output logic          o_m0_rvalid,
  output logic          o_m1_rvalid,
  output logic [AW-1:0] o_ram_addr,
  output logic          o_ram_we,
  output logic [DW-1:0] o_ram_di,
  input  logic [DW-1:0] i_ram_do
);

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RrEn = 1'b1;
`else
  localparam bit RrEn = 1'b0;
`endif

  localparam int unsigned     HW      = $clog2(MAX_HOLD);
  localparam logic [HW-1:0]   HoldLim = HW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  state_e        r_state;
  logic [HW-1:0] r_hold;
  logic          r_last_owner;
  logic [AW-1:0] r_last_addr;
  logic          r_m0_rvalid, r_m1_rvalid;
  logic [DW-1:0] r_m0_rdata, r_m1_rdata;

  logic w_gnt0, w_gnt1, w_xfer0, w_xfer1, w_cap, w_keep0, w_keep1, w_tie_m1;

  assign w_gnt0  = (r_state == StOwn0);
  assign w_gnt1  = (r_state == StOwn1);
  assign w_xfer0 = i_m0_req && w_gnt0;
  assign w_xfer1 = i_m1_req && w_gnt1;
  assign w_cap   = (r_hold >= HoldLim);

  // Whether the owner keeps the bus after a transfer while the other master waits.
  // Under fixed priority m0 never yields voluntarily; only the hold cap forces it off.
  assign w_keep0  = (i_m0_lock || !RrEn) && !w_cap;
  assign w_keep1  = i_m1_lock && !w_cap;
  assign w_tie_m1 = RrEn && !r_last_owner;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_hold       <= '0;
      r_last_owner <= 1'b1;
      r_last_addr  <= '0;
      r_m0_rvalid  <= 1'b0;
      r_m1_rvalid  <= 1'b0;
      r_m0_rdata   <= '0;
      r_m1_rdata   <= '0;
    end else begin
      r_m0_rvalid <= w_xfer0 && !i_m0_we;
      r_m1_rvalid <= w_xfer1 && !i_m1_we;
      if (w_xfer0 && !i_m0_we) r_m0_rdata <= i_ram_do;
      if (w_xfer1 && !i_m1_we) r_m1_rdata <= i_ram_do;
      if (w_xfer0 || w_xfer1) r_last_addr <= o_ram_addr;

      case (r_state)
        StIdle: begin
          r_hold <= '0;
          if (i_m0_req && (!i_m1_req || !w_tie_m1)) begin
            r_state      <= StOwn0;
            r_last_owner <= 1'b0;
          end else if (i_m1_req) begin
            r_state      <= StOwn1;
            r_last_owner <= 1'b1;
          end
        end
        StOwn0: begin
          if (!i_m0_req) begin
            r_hold  <= '0;
            r_state <= i_m1_req ? StOwn1 : StIdle;
            if (i_m1_req) r_last_owner <= 1'b1;
          end else if (!i_m1_req) begin
            r_hold <= '0;
          end else if (w_keep0) begin
            r_hold <= r_hold + HW'(1);
          end else begin
            r_hold       <= '0;
            r_state      <= StOwn1;
            r_last_owner <= 1'b1;
          end
        end
        StOwn1: begin
          if (!i_m1_req) begin
            r_hold  <= '0;
            r_state <= i_m0_req ? StOwn0 : StIdle;
            if (i_m0_req) r_last_owner <= 1'b0;
          end else if (!i_m0_req) begin
            r_hold <= '0;
          end else if (w_keep1) begin
            r_hold <= r_hold + HW'(1);
          end else begin
            r_hold       <= '0;
            r_state      <= StOwn0;
            r_last_owner <= 1'b0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Idle keeps the last transferred address on the bus so the RAM sees no spurious change.
  always_comb begin
    o_ram_addr = r_last_addr;
    o_ram_di   = '0;
    if (w_gnt0) begin
      o_ram_addr = i_m0_addr;
      o_ram_di   = i_m0_wdata;
    end else if (w_gnt1) begin
      o_ram_addr = i_m1_addr;
      o_ram_di   = i_m1_wdata;
    end
  end

  assign o_ram_we    = !i_rst && ((w_xfer0 && i_m0_we) || (w_xfer1 && i_m1_we));
  assign o_m0_gnt    = w_gnt0;
  assign o_m1_gnt    = w_gnt1;
  assign o_m0_rvalid = r_m0_rvalid;
  assign o_m1_rvalid = r_m1_rvalid;
  assign o_m0_rdata  = r_m0_rdata;
  assign o_m1_rdata  = r_m1_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed steps plus random traffic against a cycle-level ownership model.
// Honours ARB_ROUND_ROBIN_EN in the same way as the design.
module tb_mem_arbiter;
  localparam int AW       = 13;
  localparam int DW       = 8;
  localparam int MAX_HOLD = 8;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req, lock, we;
  logic [AW-1:0] addr [2];
  logic [DW-1:0] wdata [2];

  logic          gnt0, gnt1, rvalid0, rvalid1, ram_we;
  logic [DW-1:0] rdata0, rdata1, ram_di, ram_do;
  logic [AW-1:0] ram_addr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_m0_req(req[0]), .i_m1_req(req[1]),
    .i_m0_lock(lock[0]), .i_m1_lock(lock[1]),
    .i_m0_addr(addr[0]), .i_m1_addr(addr[1]),
    .i_m0_we(we[0]), .i_m1_we(we[1]),
    .i_m0_wdata(wdata[0]), .i_m1_wdata(wdata[1]),
    .o_m0_gnt(gnt0), .o_m1_gnt(gnt1),
    .o_m0_rdata(rdata0), .o_m1_rdata(rdata1),
    .o_m0_rvalid(rvalid0), .o_m1_rvalid(rvalid1),
    .o_ram_addr(ram_addr), .o_ram_we(ram_we), .o_ram_di(ram_di), .i_ram_do(ram_do)
  );

  function automatic logic [DW-1:0] init_val(input int i);
    if (i == 16) return 8'h11;
    if (i == 17) return 8'h22;
    return 8'((i * 37 + 5) & 255);
  endfunction

  // RAM stand-in: samples address/write on the falling edge, data available before next rise.
  logic [DW-1:0] ram [2**AW];
  logic [AW-1:0] ram_addr_s;
  bit            ram_loaded = 1'b0;
  always @(negedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 2**AW; i++) ram[i] <= init_val(i);
      ram_loaded <= 1'b1;
    end else if (ram_we) begin
      ram[ram_addr] <= ram_di;
    end
    ram_addr_s <= ram_addr;
  end
  assign ram_do = ram[ram_addr_s];

  // Reference model: current owner (-1 = nobody), hold count, memory image, read returns.
  int            m_owner = -1;
  int            m_hold = 0;
  int            m_last = 1;
  logic [AW-1:0] m_last_addr = '0;
  logic [DW-1:0] m_mem [2**AW];
  logic          m_rv [2];
  logic [DW-1:0] m_rd [2];
  logic          s_gnt0, s_gnt1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int  o, p, nxt;
    bit  xf;
    if (rst) begin
      m_owner = -1; m_hold = 0; m_last = 1; m_last_addr = '0;
      m_rv[0] = 1'b0; m_rv[1] = 1'b0; m_rd[0] = '0; m_rd[1] = '0;
      return;
    end
    xf = (m_owner >= 0) && req[m_owner];
    m_rv[0] = 1'b0; m_rv[1] = 1'b0;
    if (xf) begin
      m_last_addr = addr[m_owner];
      if (we[m_owner]) m_mem[addr[m_owner]] = wdata[m_owner];
      else begin
        m_rv[m_owner] = 1'b1;
        m_rd[m_owner] = m_mem[addr[m_owner]];
      end
    end
    nxt = m_owner;
    if (m_owner < 0) begin
      m_hold = 0;
      if (req[0] && req[1]) nxt = (RR && m_last == 0) ? 1 : 0;
      else if (req[0]) nxt = 0;
      else if (req[1]) nxt = 1;
    end else begin
      o = m_owner; p = 1 - o;
      if (!req[o]) begin m_hold = 0; nxt = req[p] ? p : -1; end
      else if (!req[p]) m_hold = 0;
      else if (m_hold >= MAX_HOLD - 1) begin m_hold = 0; nxt = p; end
      else if (lock[o] || (!RR && o == 0)) m_hold++;
      else begin m_hold = 0; nxt = p; end
    end
    if (nxt >= 0 && nxt != m_owner) m_last = nxt;
    m_owner = nxt;
  endtask

  // Called at posedge+1 with inputs set; checks mid-cycle, then advances one clock.
  task automatic cycle();
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_di;
    logic          e_we;
    #1;
    e_addr = (m_owner >= 0) ? addr[m_owner] : m_last_addr;
    e_di   = (m_owner >= 0) ? wdata[m_owner] : '0;
    e_we   = !rst && (m_owner >= 0) && req[m_owner] && we[m_owner];
    chk("m0_gnt", 32'(gnt0), 32'(m_owner == 0));
    chk("m1_gnt", 32'(gnt1), 32'(m_owner == 1));
    chk("ram_we", 32'(ram_we), 32'(e_we));
    chk("ram_addr", 32'(ram_addr), 32'(e_addr));
    chk("ram_di", 32'(ram_di), 32'(e_di));
    chk("m0_rvalid", 32'(rvalid0), 32'(m_rv[0]));
    chk("m1_rvalid", 32'(rvalid1), 32'(m_rv[1]));
    chk("m0_rdata", 32'(rdata0), 32'(m_rd[0]));
    chk("m1_rdata", 32'(rdata1), 32'(m_rd[1]));
    s_gnt0 = gnt0;
    s_gnt1 = gnt1;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_bus();
    req = 2'b00; lock = 2'b00; we = 2'b00;
    cycle();
    cycle();
  endtask

  initial begin
    int  run;
    bit  seen_m1, prev0, m1_after_m0;
    for (int i = 0; i < 2**AW; i++) m_mem[i] = init_val(i);
    m_rv[0] = 1'b0; m_rv[1] = 1'b0; m_rd[0] = '0; m_rd[1] = '0;
    rst = 1'b1; req = 2'b11; lock = 2'b00; we = 2'b00;
    addr[0] = 13'h0004; addr[1] = 13'h0008; wdata[0] = '0; wdata[1] = '0;

    // Reset with both masters requesting, then contention from IDLE
    @(posedge clk); #1;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) cycle();
    req[0] = 1'b0;
    cycle();
    cycle();
    idle_bus();

    // Single master write then read back
    req = 2'b01; we[0] = 1'b1; addr[0] = 13'h0003; wdata[0] = 8'h5A;
    cycle();
    cycle();
    we[0] = 1'b0;
    cycle();
    chk("single_rvalid", 32'(rvalid0), 32'd1);
    chk("single_rdata", 32'(rdata0), 32'h5A);
    req = 2'b00;
    cycle();
    idle_bus();

    // Locked m0 burst against a waiting m1: hold cap then direct handover
    req = 2'b01; lock = 2'b01; we = 2'b00; addr[0] = 13'h0040; addr[1] = 13'h0050;
    cycle();
    req = 2'b11;
    run = 0; seen_m1 = 1'b0; prev0 = 1'b1; m1_after_m0 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      addr[0] = 13'h0040 + 13'(i);
      cycle();
      if (!seen_m1) begin
        if (s_gnt0) run++;
        if (s_gnt1) begin seen_m1 = 1'b1; m1_after_m0 = prev0; end
      end
      prev0 = s_gnt0;
    end
    chk("lock_cap_run", 32'(run), 32'(MAX_HOLD));
    chk("lock_no_bubble", 32'(m1_after_m0), 32'd1);
    idle_bus();

    // Read handover m0 -> m1
    req = 2'b01; lock = 2'b00; we = 2'b00; addr[0] = 13'h0010; addr[1] = 13'h0011;
    cycle();
    req = 2'b11;
    cycle();
    req = 2'b10;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("rv_exclusive", 32'(rvalid0 & rvalid1), 32'd0);
    end
    chk("handover_rdata0", 32'(rdata0), 32'h11);
    chk("handover_rdata1", 32'(rdata1), 32'h22);
    idle_bus();

    // Reset during an m1 write to the top address
    req = 2'b10; we = 2'b10; addr[1] = 13'h1FFF; wdata[1] = 8'hC3;
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0; req = 2'b00;
    #1;
    chk("rst_gnt_clr", 32'(gnt1), 32'd0);
    chk("rst_rvalid_clr", 32'(rvalid1), 32'd0);
    req = 2'b01; we = 2'b00; addr[0] = 13'h1FFF;
    cycle();
    cycle();
    chk("rst_no_write", 32'(rdata0), 32'(init_val(8191)));
    idle_bus();

    // Random traffic, then sustained contention with random locks
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 79) == 0);
      for (int k = 0; k < 2; k++) begin
        if (n < 400) req[k] = ($urandom_range(0, 3) != 0);
        else         req[k] = 1'b1;
        lock[k]  = ($urandom_range(0, 1) == 0);
        we[k]    = ($urandom_range(0, 2) == 0);
        addr[k]  = 13'($urandom_range(0, 31)) | (($urandom_range(0, 1) == 1) ? 13'h1FE0 : 13'h0);
        wdata[k] = 8'($urandom_range(0, 255));
      end
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
